// File: rtl/piradip_state_timer_pkg.sv
// Shared definitions for the multi-channel state timer.
//   - Mode encoding constants and the mode_t enum carried on each
//     channel's 2-bit mode input.
//   - Per-channel control state enum used by the channel FSM.
package piradip_state_timer_pkg;

   localparam logic [1:0] MODE_ONESHOT_ENC  = 2'd0;
   localparam logic [1:0] MODE_PERIODIC_ENC = 2'd1;
   localparam logic [1:0] MODE_LEVEL_ENC    = 2'd2;
   localparam logic [1:0] MODE_RSVD_ENC     = 2'd3;

   typedef enum logic [1:0] {
      MODE_ONESHOT  = MODE_ONESHOT_ENC,
      MODE_PERIODIC = MODE_PERIODIC_ENC,
      MODE_LEVEL    = MODE_LEVEL_ENC,
      MODE_RSVD     = MODE_RSVD_ENC
   } mode_t;

   // IDLE : nothing pending, trigger low
   // COUNT: counting toward a fire (busy)
   // HOLD : LEVEL mode has fired, trigger held high
   typedef enum logic [1:0] {
      CH_IDLE  = 2'd0,
      CH_COUNT = 2'd1,
      CH_HOLD  = 2'd2
   } chan_st_t;

endpackage

// File: rtl/piradip_state_timer_chan.sv
// One state-timer channel.
// Watches a state word; on a change it loads the delay and counts down,
// firing a trigger C+1 edges after the change according to the mode.
// Ports:
//   clk, rstn     clock and synchronous active-low reset
//   en            channel enable; low clears the count and trigger
//   state         watched state word
//   cycles        delay C, sampled on each load
//   mode          ONESHOT / PERIODIC / LEVEL (reserved acts as ONESHOT)
//   trigger       registered trigger output
//   busy          counting toward a fire
//   remaining     live counter value
//   trigger_next  value trigger takes at the next edge (feeds the
//                 top-level registered OR so it lines up with trigger)
module piradip_state_timer_chan
   import piradip_state_timer_pkg::*;
#(
   parameter int REG_WIDTH   = 32,
   parameter int STATE_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en,
   input  logic [STATE_WIDTH-1:0] state,
   input  logic [REG_WIDTH-1:0]   cycles,
   input  logic [1:0]             mode,
   output logic                   trigger,
   output logic                   busy,
   output logic [REG_WIDTH-1:0]   remaining,
   output logic                   trigger_next
);

   chan_st_t               st, st_next;
   logic [STATE_WIDTH-1:0] old_state;
   logic [REG_WIDTH-1:0]   counter, counter_next;
   logic                   change;
   mode_t                  cur_mode;

   assign change   = (state != old_state);
   assign cur_mode = mode_t'(mode);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         st        <= CH_IDLE;
         old_state <= '0;
         counter   <= '0;
         trigger   <= 1'b0;
      end else begin
         st        <= st_next;
         // old_state tracks even while disabled so re-enabling needs a
         // fresh change before anything fires
         old_state <= state;
         counter   <= counter_next;
         trigger   <= trigger_next;
      end
   end

   always_comb begin
      st_next      = st;
      counter_next = counter;
      trigger_next = (st == CH_HOLD);

      if (!en) begin
         st_next      = CH_IDLE;
         counter_next = '0;
         trigger_next = 1'b0;
      end else if (change) begin
         // a change always restarts, even on the edge that would fire
         st_next      = CH_COUNT;
         counter_next = cycles;
         trigger_next = 1'b0;
      end else if (st == CH_COUNT) begin
         if (counter != '0) begin
            counter_next = counter - REG_WIDTH'(1);
         end else begin
            trigger_next = 1'b1;
            case (cur_mode)
               MODE_PERIODIC: counter_next = cycles;
               MODE_LEVEL:    st_next      = CH_HOLD;
               default:       st_next      = CH_IDLE;
            endcase
         end
      end
   end

   assign busy      = (st == CH_COUNT);
   assign remaining = counter;

endmodule

// File: rtl/piradip_state_timer_mc.sv
// Multi-channel state timer.
// NUM_CHANNELS independent channels, each firing a trigger a programmed
// number of cycles after its watched state word changes, in one-shot,
// periodic or level mode.
// Ports:
//   clk, rstn   clock and synchronous active-low reset
//   en          per-channel enable
//   state       state words, channel i at [i*STATE_WIDTH +: STATE_WIDTH]
//   cycles      per-channel delay, channel i at [i*REG_WIDTH +: REG_WIDTH]
//   mode        per-channel 2-bit mode, channel i at [2*i +: 2]
//   trigger     per-channel registered trigger
//   busy        per-channel counting flag
//   remaining   per-channel live counter
//   trig_any    registered OR of all triggers, aligned with trigger
module piradip_state_timer_mc
   import piradip_state_timer_pkg::*;
#(
   parameter int REG_WIDTH    = 32,
   parameter int STATE_WIDTH  = 8,
   parameter int NUM_CHANNELS = 4
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [NUM_CHANNELS-1:0]           en,
   input  logic [NUM_CHANNELS*STATE_WIDTH-1:0] state,
   input  logic [NUM_CHANNELS*REG_WIDTH-1:0] cycles,
   input  logic [NUM_CHANNELS*2-1:0]         mode,
   output logic [NUM_CHANNELS-1:0]           trigger,
   output logic [NUM_CHANNELS-1:0]           busy,
   output logic [NUM_CHANNELS*REG_WIDTH-1:0] remaining,
   output logic                              trig_any
);

   logic [NUM_CHANNELS-1:0] trig_next;

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
      piradip_state_timer_chan #(
         .REG_WIDTH   (REG_WIDTH),
         .STATE_WIDTH (STATE_WIDTH)
      ) u_chan (
         .clk          (clk),
         .rstn         (rstn),
         .en           (en[i]),
         .state        (state[i*STATE_WIDTH +: STATE_WIDTH]),
         .cycles       (cycles[i*REG_WIDTH +: REG_WIDTH]),
         .mode         (mode[2*i +: 2]),
         .trigger      (trigger[i]),
         .busy         (busy[i]),
         .remaining    (remaining[i*REG_WIDTH +: REG_WIDTH]),
         .trigger_next (trig_next[i])
      );
   end

   // OR the next-trigger values so trig_any is registered yet lands in
   // the same cycle as the per-channel triggers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         trig_any <= 1'b0;
      end else begin
         trig_any <= |trig_next;
      end
   end

endmodule

// File: tb/tb_piradip_state_timer_mc.sv
// Directed bench for piradip_state_timer_mc (4 channels, 32-bit counters,
// 8-bit state words). Inputs change #1 after a rising edge and outputs are
// examined in that same window, after the edge has settled.
module tb_piradip_state_timer_mc;

   logic         clk;
   logic         rstn;
   logic [3:0]   en;
   logic [31:0]  state;
   logic [127:0] cycles;
   logic [7:0]   mode;
   logic [3:0]   trigger;
   logic [3:0]   busy;
   logic [127:0] remaining;
   logic         trig_any;

   int checks   = 0;
   int failures = 0;

   piradip_state_timer_mc #(
      .REG_WIDTH    (32),
      .STATE_WIDTH  (8),
      .NUM_CHANNELS (4)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .state     (state),
      .cycles    (cycles),
      .mode      (mode),
      .trigger   (trigger),
      .busy      (busy),
      .remaining (remaining),
      .trig_any  (trig_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic [7:0] s, input logic [31:0] c,
                         input logic [1:0] m);
      state[ch*8 +: 8]   = s;
      cycles[ch*32 +: 32] = c;
      mode[ch*2 +: 2]    = m;
   endtask

   function automatic logic [31:0] rem(input int ch);
      return remaining[ch*32 +: 32];
   endfunction

   logic [3:0] exp_trig [7];
   logic       exp_any  [7];

   initial begin
      rstn   = 1'b0;
      en     = 4'h0;
      state  = '0;
      cycles = '0;
      mode   = '0;

      // reset state
      tick();
      tick();
      chk("rst_trigger", 32'(trigger), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_remaining0", rem(0), 32'd0);
      chk("rst_remaining3", rem(3), 32'd0);
      chk("rst_trig_any", 32'(trig_any), 32'd0);

      rstn = 1'b1;
      en   = 4'hF;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // ONESHOT C=3: remaining 3,2,1,0 after E0..E3, pulse after E4
      set_ch(0, 8'd5, 32'd3, 2'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("os3_rem_e%0d", k), rem(0), 32'(3 - k));
         chk($sformatf("os3_trig_e%0d", k), 32'(trigger), 32'd0);
         chk($sformatf("os3_busy_e%0d", k), 32'(busy), 32'd1);
      end
      tick();
      chk("os3_fire_trig", 32'(trigger), 32'd1);
      chk("os3_fire_any", 32'(trig_any), 32'd1);
      chk("os3_fire_busy", 32'(busy), 32'd0);
      tick();
      chk("os3_after_trig", 32'(trigger), 32'd0);
      chk("os3_after_any", 32'(trig_any), 32'd0);

      // ONESHOT C=0: pulse after E1
      set_ch(0, 8'd6, 32'd0, 2'd0);
      tick();
      chk("os0_e0_busy", 32'(busy), 32'd1);
      chk("os0_e0_trig", 32'(trigger), 32'd0);
      tick();
      chk("os0_e1_trig", 32'(trigger), 32'd1);
      tick();
      chk("os0_e2_trig", 32'(trigger), 32'd0);

      // PERIODIC C=0: fires every cycle while state is held
      set_ch(0, 8'd7, 32'd0, 2'd1);
      tick();
      chk("per0_e0_trig", 32'(trigger), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("per0_e%0d_trig", k), 32'(trigger), 32'd1);
         chk($sformatf("per0_e%0d_any", k), 32'(trig_any), 32'd1);
      end

      // PERIODIC C=2: period 3; cycles=4 mid-run gives a 5-cycle interval
      set_ch(0, 8'd8, 32'd2, 2'd1);
      tick(); // E0
      chk("per2_e0_trig", 32'(trigger), 32'd0);
      chk("per2_e0_rem", rem(0), 32'd2);
      tick(); // E1
      chk("per2_e1_trig", 32'(trigger), 32'd0);
      tick(); // E2
      chk("per2_e2_rem", rem(0), 32'd0);
      tick(); // E3
      chk("per2_e3_trig", 32'(trigger), 32'd1);
      chk("per2_e3_rem", rem(0), 32'd2);
      tick(); // E4
      chk("per2_e4_trig", 32'(trigger), 32'd0);
      cycles[31:0] = 32'd4;
      tick(); // E5
      chk("per2_e5_trig", 32'(trigger), 32'd0);
      chk("per2_e5_rem", rem(0), 32'd0);
      tick(); // E6
      chk("per2_e6_trig", 32'(trigger), 32'd1);
      chk("per2_e6_rem", rem(0), 32'd4);
      for (int k = 7; k <= 10; k++) begin
         tick();
         chk($sformatf("per4_e%0d_trig", k), 32'(trigger), 32'd0);
      end
      tick(); // E11
      chk("per4_e11_trig", 32'(trigger), 32'd1);
      state[7:0] = 8'd9;
      tick(); // E12: change restarts
      chk("per_chg_trig", 32'(trigger), 32'd0);
      chk("per_chg_rem", rem(0), 32'd4);
      chk("per_chg_busy", 32'(busy), 32'd1);
      en[0] = 1'b0;
      tick();
      chk("per_dis_busy", 32'(busy), 32'd0);
      chk("per_dis_rem", rem(0), 32'd0);
      en[0] = 1'b1;
      tick();
      chk("per_reen_busy", 32'(busy), 32'd0);

      // Restart: ONESHOT C=5, change at remaining=1 and on the fire edge
      set_ch(0, 8'd10, 32'd5, 2'd0);
      for (int k = 0; k < 5; k++) tick(); // E0..E4
      chk("rs_e4_rem", rem(0), 32'd1);
      state[7:0] = 8'd11;
      tick(); // E5
      chk("rs_e5_trig", 32'(trigger), 32'd0);
      chk("rs_e5_rem", rem(0), 32'd5);
      for (int k = 6; k <= 10; k++) begin
         tick();
         chk($sformatf("rs_e%0d_trig", k), 32'(trigger), 32'd0);
      end
      chk("rs_e10_rem", rem(0), 32'd0);
      state[7:0] = 8'd12;
      tick(); // E11: would have fired
      chk("rs_e11_trig", 32'(trigger), 32'd0);
      chk("rs_e11_rem", rem(0), 32'd5);
      for (int k = 12; k <= 16; k++) begin
         tick();
         chk($sformatf("rs_e%0d_trig", k), 32'(trigger), 32'd0);
      end
      tick(); // E17
      chk("rs_e17_trig", 32'(trigger), 32'd1);
      tick();
      chk("rs_e18_trig", 32'(trigger), 32'd0);

      // LEVEL C=2: rises after E3, holds, cleared by change and by en=0
      set_ch(0, 8'd13, 32'd2, 2'd2);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("lv_e%0d_trig", k), 32'(trigger), 32'd0);
      end
      tick(); // E3
      chk("lv_e3_trig", 32'(trigger), 32'd1);
      chk("lv_e3_busy", 32'(busy), 32'd0);
      tick();
      tick(); // E5
      chk("lv_e5_hold", 32'(trigger), 32'd1);
      chk("lv_e5_any", 32'(trig_any), 32'd1);
      state[7:0] = 8'd14;
      tick(); // E6
      chk("lv_chg_trig", 32'(trigger), 32'd0);
      chk("lv_chg_rem", rem(0), 32'd2);
      tick();
      tick();
      tick(); // E9
      chk("lv_e9_trig", 32'(trigger), 32'd1);
      en[0] = 1'b0;
      tick();
      chk("lv_dis_trig", 32'(trigger), 32'd0);
      en[0] = 1'b1;
      tick();
      chk("lv_reen_trig", 32'(trigger), 32'd0);
      chk("lv_reen_busy", 32'(busy), 32'd0);
      tick();
      chk("lv_reen2_trig", 32'(trigger), 32'd0);

      // Concurrent channels, all changing at E0:
      //   ch0 ONESHOT C=4 -> E5; ch1 PERIODIC C=1 -> E2,E4,E6;
      //   ch2 LEVEL C=3 -> E4 onward; ch3 ONESHOT C=0 -> E1
      exp_trig = '{4'b0000, 4'b1000, 4'b0010, 4'b0000, 4'b0110, 4'b0101, 4'b0110};
      exp_any  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      set_ch(0, 8'd20, 32'd4, 2'd0);
      set_ch(1, 8'd1,  32'd1, 2'd1);
      set_ch(2, 8'd2,  32'd3, 2'd2);
      set_ch(3, 8'd3,  32'd0, 2'd0);
      for (int k = 0; k < 7; k++) begin
         tick();
         chk($sformatf("mc_e%0d_trig", k), 32'(trigger), 32'(exp_trig[k]));
         chk($sformatf("mc_e%0d_any", k), 32'(trig_any), 32'(exp_any[k]));
      end
      chk("mc_e6_busy", 32'(busy), 32'b0010);

      // Reset mid-count at remaining=2 drops the pending fire
      state[7:0] = 8'd21;
      tick();
      tick();
      tick();
      chk("rm_pre_rem", rem(0), 32'd2);
      rstn = 1'b0;
      tick();
      chk("rm_trig", 32'(trigger), 32'd0);
      chk("rm_busy", 32'(busy), 32'd0);
      chk("rm_rem0", rem(0), 32'd0);
      chk("rm_any", 32'(trig_any), 32'd0);
      rstn = 1'b1;
      en   = 4'b0001;
      tick(); // nonzero state vs cleared old_state counts as a change
      chk("rm_rel_busy", 32'(busy), 32'b0001);
      chk("rm_rel_rem", rem(0), 32'd4);
      chk("rm_rel_trig", 32'(trigger), 32'd0);
      tick();
      chk("rm_rel2_trig", 32'(trigger), 32'd0);
      chk("rm_rel2_rem", rem(0), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/piradip_state_timer_mc.md
Name: piradip_state_timer_mc

Overview:
Multi-channel, mode-selectable successor to the single-channel state timer. Each of NUM_CHANNELS independent channels watches a state word and fires a trigger a programmed number of cycles after the state changes. Each channel runs in one of three modes: one-shot, periodic or level. Sits beside sequencer/control FSMs to time RF switch settling, TX/RX turnaround and similar delays.

Parameters:
REG_WIDTH, 32, width of cycles count and remaining counter per channel
STATE_WIDTH, 8, width of each channel's watched state word
NUM_CHANNELS, 4, number of independent timer channels (>=1)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset, sampled on rising clk; one clock, reset is synchronous and active-low
en  in  NUM_CHANNELS  per-channel enable
state  in  NUM_CHANNELS*STATE_WIDTH  watched state words; channel i at [i*STATE_WIDTH +: STATE_WIDTH]
cycles  in  NUM_CHANNELS*REG_WIDTH  per-channel delay C
mode  in  NUM_CHANNELS*2  per-channel mode: 0 ONESHOT, 1 PERIODIC, 2 LEVEL, 3 reserved (behaves as ONESHOT)
trigger  out  NUM_CHANNELS  per-channel trigger, registered
busy  out  NUM_CHANNELS  channel counting toward a fire
remaining  out  NUM_CHANNELS*REG_WIDTH  live counter value per channel
trig_any  out  1  registered OR of trigger (same cycle as trigger)

Behaviour:
- Reset: old_state, counter, busy, trigger, trig_any all 0. Reset mid-count drops any pending fire. The first nonzero state after reset counts as a change.
- Every edge with en=1: old_state <= state. A change is detected when state != old_state.
- Change at edge E0: busy <= 1, counter <= cycles (sampled at E0). In LEVEL mode trigger also clears at E0.
- Edge with busy=1 and counter>0: counter decrements.
- Edge with busy=1, counter=0 and no change (fire):
  - ONESHOT: trigger high for exactly 1 cycle; busy <= 0.
  - PERIODIC: trigger pulses 1 cycle; counter <= live cycles input; busy stays 1.
  - LEVEL: trigger set and held until next change or en=0; busy <= 0.
- Latency: trigger first high in the cycle after edge E(C+1), i.e. C+1 edges after the detecting edge E0. C=0 gives 1-cycle latency. PERIODIC period is C+1 cycles; C=0 in PERIODIC fires every cycle.
- Change during count, including on the fire edge: restart wins. No trigger; counter reloads from cycles. In LEVEL mode the held trigger drops.
- Changes to the cycles input while counting are ignored until the next load (change or periodic reload).
- Changes to the mode input take effect at the next fire decision.
- en=0 at an edge: busy, counter and trigger cleared; old_state still tracks state, so re-enabling does not fire without a fresh change.
- ONESHOT/PERIODIC pulse outputs never stretch; back-to-back pulses occur only in PERIODIC with C=0.
- Channels are fully independent; no arbitration.
- counter never underflows; remaining = counter.

Decomposition:
- Package piradip_state_timer_pkg: mode typedef (2-bit enum ONESHOT/PERIODIC/LEVEL/RSVD) and the mode encoding constants.
- Sub-module piradip_state_timer_chan: one channel (old_state, counter, busy, trigger logic), parametrised by REG_WIDTH and STATE_WIDTH.
- Top level: generate loop over NUM_CHANNELS, slicing the buses, plus the registered trig_any OR.

Test Plan:
- ONESHOT, C=3, ch0 state 0->5 detected at E0 -> remaining 3,2,1,0 after E0..E3; single trigger[0] pulse after E4; busy drops with it; trig_any coincident.
- C=0 ONESHOT -> pulse in the cycle after E1. C=0 PERIODIC with state held -> trigger high every cycle.
- PERIODIC, C=2 -> pulses every 3 cycles. Set cycles=4 mid-run -> the current interval is unaffected and the next interval is 5 cycles. A state change stops the pulse train and restarts the count.
- Restart: ONESHOT C=5, new state change when remaining=1, and separately on the fire edge -> no pulse in either case; pulse C+1 edges after the second change.
- LEVEL, C=2 -> trigger rises after E3 and holds. Next change clears it at that edge. en=0 clears it; re-enable with state unchanged -> no fire.
- Reset asserted at remaining=2 -> all outputs 0 after that edge, no pulse. Concurrently, ch1..ch3 with different modes/C -> each fires at its own predicted cycle, no cross-talk.
